// File: rtl/sha2_pkg.sv
// Shared constants for the SHA-2 hash state bank: initial hash values,
// FSM state encoding and the supported word width.
package sha2_pkg;

    localparam int SHA2_WORD_W = 32;

    localparam logic [0:7][31:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:7][31:0] SHA224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_READOUT = 1'b1
    } state_t;

    function automatic logic [31:0] iv_word(input int sel, input int i);
        return (sel != 0) ? SHA224_IV[i] : SHA256_IV[i];
    endfunction

endpackage

// File: rtl/hash_word_reg.sv
// One hash state word: async reset and synchronous reload to its IV,
// otherwise accumulates add_val modulo 2^WORD_W when add_en is high.
module hash_word_reg
    import sha2_pkg::*;
#(
    parameter int                WORD_W = SHA2_WORD_W,
    parameter logic [WORD_W-1:0] IV     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              add_en,
    input  logic [WORD_W-1:0] add_val,
    output logic [WORD_W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= IV;
        end else if (init) begin
            q <= IV;
        end else if (add_en) begin
            q <= q + add_val;
        end
    end

endmodule

// File: rtl/hash_state_bank.sv
// SHA-256/224 intermediate hash state H0..H7: IV load, per-block accumulation
// of the working variables, and word-serial digest readout over valid/ready.
module hash_state_bank
    import sha2_pkg::*;
#(
    parameter int IV_SEL = 0,
    parameter int WORD_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [8*WORD_W-1:0] upd_data,
    input  logic                out_start,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_data,
    output logic                out_last,
    output logic                busy
);

    if (WORD_W != SHA2_WORD_W) begin : g_bad_width
        $error("hash_state_bank: only WORD_W = 32 is supported");
    end

    localparam int         NWORDS   = 8 - IV_SEL;
    localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);

    state_t            state;
    logic [2:0]        idx;
    logic              add_en;
    logic [WORD_W-1:0] h [8];

    // Init has priority over an update; updates are only taken while idle.
    assign add_en = (state == ST_IDLE) && !init && upd_valid;

    for (genvar i = 0; i < 8; i++) begin : g_word
        hash_word_reg #(
            .WORD_W (WORD_W),
            .IV     (WORD_W'(iv_word(IV_SEL, i)))
        ) u_word (
            .clk     (clk),
            .reset   (reset),
            .init    (init),
            .add_en  (add_en),
            .add_val (upd_data[8*WORD_W-1-WORD_W*i -: WORD_W]),
            .q       (h[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!init && !upd_valid && out_start) begin
                        state <= ST_READOUT;
                        idx   <= 3'd0;
                    end
                end
                ST_READOUT: begin
                    if (init) begin
                        state <= ST_IDLE;
                        idx   <= 3'd0;
                    end else if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                            idx   <= 3'd0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    idx   <= 3'd0;
                end
            endcase
        end
    end

    // Outputs decode only the state/idx registers, so reset clears them at once.
    assign busy      = (state == ST_READOUT);
    assign out_valid = busy;
    assign upd_ready = !busy;
    assign out_last  = busy && (idx == LAST_IDX);
    assign out_data  = busy ? h[idx] : '0;

endmodule

// File: tb/tb_hash_state_bank.sv
// Directed bench for hash_state_bank: SHA-256 and SHA-224 instances driven
// from shared inputs, expected digest words computed by hand.
module tb_hash_state_bank;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         init = 1'b0;
    logic         upd_valid = 1'b0;
    logic [255:0] upd_data = '0;
    logic         out_start = 1'b0;
    logic         out_ready = 1'b0;

    logic        upd_ready0, out_valid0, out_last0, busy0;
    logic [31:0] out_data0;
    logic        upd_ready1, out_valid1, out_last1, busy1;
    logic [31:0] out_data1;

    logic        sel = 1'b0;
    logic        o_rdy, o_vld, o_last, o_busy;
    logic [31:0] o_data;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] iv256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] ivm1  [8] = '{32'h6a09e666, 32'hbb67ae84, 32'h3c6ef371, 32'ha54ff539,
                               32'h510e527e, 32'h9b05688b, 32'h1f83d9aa, 32'h5be0cd18};
    logic [31:0] iv224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                               32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

    hash_state_bank #(.IV_SEL(0), .WORD_W(32)) dut0 (
        .clk(clk), .reset(reset), .init(init), .upd_valid(upd_valid),
        .upd_ready(upd_ready0), .upd_data(upd_data), .out_start(out_start),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_last(out_last0), .busy(busy0)
    );

    hash_state_bank #(.IV_SEL(1), .WORD_W(32)) dut1 (
        .clk(clk), .reset(reset), .init(init), .upd_valid(upd_valid),
        .upd_ready(upd_ready1), .upd_data(upd_data), .out_start(out_start),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_last(out_last1), .busy(busy1)
    );

    assign o_rdy  = sel ? upd_ready1 : upd_ready0;
    assign o_vld  = sel ? out_valid1 : out_valid0;
    assign o_last = sel ? out_last1  : out_last0;
    assign o_busy = sel ? busy1      : busy0;
    assign o_data = sel ? out_data1  : out_data0;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input string tag);
        chk1({tag, "_valid"}, o_vld, 1'b0);
        chk1({tag, "_busy"}, o_busy, 1'b0);
        chk1({tag, "_last"}, o_last, 1'b0);
        chk1({tag, "_updrdy"}, o_rdy, 1'b1);
        chk({tag, "_data"}, o_data, 32'h0);
    endtask

    task automatic readout(input string tag, input logic [31:0] exp [8], input int n);
        out_ready = 1'b1;
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk1($sformatf("%s_v%0d", tag, i), o_vld, 1'b1);
            chk($sformatf("%s_w%0d", tag, i), o_data, exp[i]);
            chk1($sformatf("%s_l%0d", tag, i), o_last, 1'(i == n - 1));
            tick();
        end
        idle_chk({tag, "_end"});
    endtask

    task automatic update(input logic [255:0] d);
        upd_valid = 1'b1;
        upd_data  = d;
        tick();
        upd_valid = 1'b0;
        upd_data  = '0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        idle_chk("rst");
        reset = 1'b0;
        tick();
        idle_chk("rst_rel");

        // Plain IV readout, SHA-256
        readout("iv", iv256, 8);

        // Accumulate all-ones: every word wraps to IV-1
        update({8{32'hffffffff}});
        idle_chk("post_upd");
        readout("wrap", ivm1, 8);
        init = 1'b1;
        tick();
        init = 1'b0;
        readout("reinit", iv256, 8);

        // Backpressure at idx 2, update attempt during readout
        out_ready = 1'b1;
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        chk("bp_w0", o_data, iv256[0]);
        tick();
        chk("bp_w1", o_data, iv256[1]);
        tick();
        out_ready = 1'b0;
        upd_valid = 1'b1;
        upd_data  = {8{32'hffffffff}};
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d", i), o_data, 32'h3c6ef372);
            chk1($sformatf("bp_vld%0d", i), o_vld, 1'b1);
            chk1($sformatf("bp_last%0d", i), o_last, 1'b0);
            chk1($sformatf("bp_updrdy%0d", i), o_rdy, 1'b0);
            tick();
        end
        upd_valid = 1'b0;
        upd_data  = '0;
        chk("bp_hold3", o_data, 32'h3c6ef372);
        out_ready = 1'b1;
        tick();
        chk("bp_resume", o_data, 32'ha54ff53a);
        for (int i = 4; i < 8; i++) begin
            tick();
            chk($sformatf("bp_w%0d", i), o_data, iv256[i]);
        end
        chk1("bp_last", o_last, 1'b1);
        tick();
        idle_chk("bp_end");
        readout("bp_unchanged", iv256, 8);

        // Init, update and out_start together: only the IV load happens
        update({8{32'hffffffff}});
        init      = 1'b1;
        upd_valid = 1'b1;
        upd_data  = {8{32'h00000001}};
        out_start = 1'b1;
        tick();
        init      = 1'b0;
        upd_valid = 1'b0;
        upd_data  = '0;
        out_start = 1'b0;
        idle_chk("prio");
        readout("prio", iv256, 8);

        // Async reset at idx 4
        update({8{32'hffffffff}});
        out_ready = 1'b1;
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("ar_w4", o_data, 32'h510e527e);
        #1;
        reset = 1'b1;
        #1;
        chk1("ar_vld", o_vld, 1'b0);
        chk1("ar_busy", o_busy, 1'b0);
        chk("ar_data", o_data, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        idle_chk("ar_idle");
        readout("ar", iv256, 8);

        // Init abort at idx 5
        update({8{32'hffffffff}});
        out_ready = 1'b1;
        out_start = 1'b1;
        tick();
        out_start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("ab_w5", o_data, 32'h9b05688b);
        init = 1'b1;
        tick();
        init = 1'b0;
        idle_chk("ab");
        tick();
        idle_chk("ab_next");
        readout("ab", iv256, 8);

        // SHA-224 instance
        reset = 1'b1;
        sel   = 1'b1;
        tick();
        idle_chk("s224_rst");
        reset = 1'b0;
        tick();
        readout("s224", iv224, 7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hash_state_bank.md
Name: hash_state_bank

Overview:
- Parametrised successor to the single 32-bit hash register.
- Holds the full SHA-2 intermediate hash state (H0..H7) for the SHA-256/224 core.
- Loads the standard IV, accumulates compression-round results (H[i] += working var), and streams the digest out word-by-word over a valid/ready handshake.
- Sits between the compression round engine and the digest output interface.

Parameters:
- IV_SEL, 0, IV and digest-length select: 0 = SHA-256 (8 output words), 1 = SHA-224 (7 output words).
- WORD_W, 32, word width. Only 32 is supported; any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- init  input  1  synchronous reload of IV into H0..H7
- upd_valid  input  1  working-variable update request
- upd_ready  output  1  update can be accepted
- upd_data  input  256  working vars a..h; a = [255:224], h = [31:0]
- out_start  input  1  begin digest readout
- out_valid  output  1  out_data holds a digest word
- out_ready  input  1  consumer accepts word
- out_data  output  32  current digest word, H0 first
- out_last  output  1  final digest word (H7, or H6 when IV_SEL=1)
- busy  output  1  readout in progress

Behaviour:
- Reset (async, active-high):
  - H[i] = IV[IV_SEL][i]; state = IDLE; idx = 0.
  - out_valid = 0, out_last = 0, busy = 0, upd_ready = 1, out_data = 0.
- States: IDLE, READOUT.
- IDLE, priority init > update > out_start, one action per cycle:
  - init = 1: H loads IV next cycle; upd_valid and out_start are ignored that cycle.
  - upd_valid && upd_ready: H[i] <= (H[i] + upd_data word i) mod 2^32 for all 8 words in one cycle. Result is visible the next cycle. Overflow wraps silently.
  - out_start = 1 with no init or update: go to READOUT with idx = 0.
- READOUT:
  - upd_ready = 0 and busy = 1; out_valid = 1 from the first READOUT cycle.
  - out_data = H[idx], combinational from the registered idx. out_data = 0 whenever out_valid = 0.
  - out_last = 1 when idx == NWORDS-1, where NWORDS = 8 - IV_SEL.
  - On out_valid && out_ready: idx increments; if out_last, return to IDLE and clear idx.
  - With out_ready low: out_data, out_last and idx hold stable indefinitely.
  - out_start while in READOUT is ignored (no restart).
  - init in READOUT: abort, IV reload, return to IDLE; out_valid = 0 next cycle. No further handshake completes.
  - H is never modified by readout; the digest can be read repeatedly.
- Latency: update 1 cycle; out_start to first out_valid 1 cycle; back-to-back words at 1 per cycle with out_ready held high. A full SHA-256 readout takes 8 cycles after entering READOUT.
- Reset asserted mid-readout: immediate return to reset values, including out_valid = 0 asynchronously.
- H7 is held and updated when IV_SEL = 1 but never output.

Decomposition:
- Package sha2_pkg:
  - SHA256_IV[0:7] = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19
  - SHA224_IV[0:7] = c1059ed8 367cd507 3070dd17 f70e5939 ffc00b31 68581511 64f98fa7 befa4fa4
  - state encoding constants ST_IDLE / ST_READOUT
  - word-width constant
- One natural sub-module: hash_word_reg. It is a single 32-bit register with async reset to a parameter IV, plus init / add-enable. It is instantiated 8 times via generate.

Test Plan:
- Reset, IV_SEL=0, then out_start with out_ready=1 -> 8 words 6a09e667 ... 5be0cd19 on consecutive cycles; out_last only on 5be0cd19; busy falls the cycle after.
- Update with upd_data all-ones (each word ffffffff) -> readout 6a09e666, bb67ae84, ..., 5be0cd18 (wrap-around). Then init -> IV restored.
- Readout with out_ready low for 3 cycles at idx=2 -> out_data held at 3c6ef372 with out_valid=1; resumes to a54ff53a after ready rises. upd_valid during READOUT is not accepted (upd_ready=0, H unchanged).
- Same cycle in IDLE: init=1, upd_valid=1 (data 00000001 x8), out_start=1 -> only IV load; next cycle still IDLE; a subsequent readout returns the pure IV.
- Reset asserted at idx=4 mid-readout -> out_valid=0 immediately; IDLE; H = IV. Init at idx=5 -> out_valid=0 next cycle, no word 5 handshake.
- IV_SEL=1: reset then readout -> 7 words c1059ed8 ... 64f98fa7; out_last on 64f98fa7; befa4fa4 never output.
